// File: rtl/deserialize_if.sv
// Receive-side link bundle for deserialize: serial sda/scl in, word handshake out.
interface deserialize_if #(
    parameter int WIDTH = 8
);
    logic             scl;
    logic             sda;
    logic             iack;
    logic [WIDTH-1:0] data;
    logic             ordy;
    logic             busy;
    logic             err;
    logic             ovr;

    // Link source plus word consumer: drives the serial lines and the acknowledge.
    modport master (
        output scl, sda, iack,
        input  data, ordy, busy, err, ovr
    );

    // The deserializer itself.
    modport slave (
        input  scl, sda, iack,
        output data, ordy, busy, err, ovr
    );
endinterface

// File: rtl/deserialize.sv
// Serial-to-parallel receiver for the sda/scl link. scl is oversampled as data
// in the cin domain; sda is captured on each trailing scl edge, MSB first, and
// completed words are offered on data with an ordy/iack handshake.
module deserialize #(
    parameter int SCL_MODE = 1,   // 1: scl idles low; 0: scl idles high
    parameter int WIDTH    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic         cin,
    input  logic         reset_n,
    deserialize_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic          IDLE   = (SCL_MODE != 0) ? 1'b0 : 1'b1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    // [0],[1] are the metastability stages, [2] is the edge-detect delay.
    // sda runs through the same depth so sda_q[2] lines up with scl_q[2]
    // (the last sample taken while scl was still in its pulse level).
    logic [2:0]       scl_q, sda_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    to_q, to_d;
    logic             ordy_q, ordy_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;

    logic             te;
    logic             complete;
    logic [WIDTH-1:0] word;

    // Resynchronise the asynchronous serial lines, preset to the idle level.
    always_ff @(posedge cin or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= {3{IDLE}};
            sda_q <= {3{IDLE}};
        end else begin
            scl_q <= {scl_q[1:0], bus.scl};
            sda_q <= {sda_q[1:0], bus.sda};
        end
    end

    // Trailing edge of an scl pulse and the word it would complete.
    always_comb begin
        te       = (SCL_MODE != 0) ? (scl_q[2] & ~scl_q[1]) : (~scl_q[2] & scl_q[1]);
        word     = {shreg_q[WIDTH-2:0], sda_q[2]};
        complete = te && (cnt_q == LAST);
    end

    // Bit assembly, mid-word timeout and the output handshake.
    always_comb begin
        shreg_d = shreg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        ordy_d  = ordy_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;

        if (te) begin
            shreg_d = word;
            to_d    = '0;
            cnt_d   = complete ? '0 : cnt_q + CW'(1);
        end else if (cnt_q != '0) begin
            // Stalled mid-word: give up after TIMEOUT quiet cycles.
            if (to_q == TO_MAX) begin
                cnt_d   = '0;
                to_d    = '0;
                shreg_d = '0;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
        end else begin
            to_d = '0;
        end

        // A word may replace the held one only when that one is taken this cycle.
        if (complete) begin
            if (!ordy_q || bus.iack) begin
                data_d = word;
                ordy_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ordy_q && bus.iack) begin
            ordy_d = 1'b0;
        end

        busy_d = (cnt_d != '0);
    end

    // Receiver state registers.
    always_ff @(posedge cin or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            ordy_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            ordy_q  <= ordy_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data = data_q;
    assign bus.ordy = ordy_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_deserialize.sv
// Randomised self-checking bench for deserialize: one receiver per scl polarity,
// a serial-link driver, an auto-acknowledging consumer and a word-queue reference.
module tb_deserialize;
    localparam int W  = 8;
    localparam int TO = 64;

    logic cin;
    logic reset_n;

    deserialize_if #(.WIDTH(W)) bus1 ();
    deserialize_if #(.WIDTH(W)) bus0 ();

    deserialize #(.SCL_MODE(1), .WIDTH(W), .TIMEOUT(TO)) u_dut1 (
        .cin(cin), .reset_n(reset_n), .bus(bus1.slave)
    );
    deserialize #(.SCL_MODE(0), .WIDTH(W), .TIMEOUT(TO)) u_dut0 (
        .cin(cin), .reset_n(reset_n), .bus(bus0.slave)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    int errs   = 0;
    int checks = 0;

    int err1 = 0, ovr1 = 0, err0 = 0, ovr0 = 0;
    bit auto1 = 1'b0, auto0 = 1'b0;
    logic [W-1:0] rx1[$];
    logic [W-1:0] rx0[$];
    logic [W-1:0] sent[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge cin);
    endtask

    // Consumer and pulse counters: acknowledges a held word when enabled and
    // logs every accepted word in order.
    always @(negedge cin) begin
        if (bus1.err) err1++;
        if (bus1.ovr) ovr1++;
        if (bus0.err) err0++;
        if (bus0.ovr) ovr0++;
        if (auto1 && bus1.ordy === 1'b1) begin
            rx1.push_back(bus1.data);
            bus1.iack = 1'b1;
        end else begin
            bus1.iack = 1'b0;
        end
        if (auto0 && bus0.ordy === 1'b1) begin
            rx0.push_back(bus0.data);
            bus0.iack = 1'b1;
        end else begin
            bus0.iack = 1'b0;
        end
    end

    // One scl pulse carrying bit b; sda wanders first to show it is ignored
    // between pulses. Entered and left on a cin falling edge.
    task automatic send_bit(input bit m, input bit b, input int half);
        int lo, hi;
        lo = (half != 0) ? half : int'($urandom_range(4, 9));
        hi = (half != 0) ? half : int'($urandom_range(4, 9));
        if (m) bus1.sda = 1'($urandom); else bus0.sda = 1'($urandom);
        @(negedge cin);
        if (m) bus1.sda = b; else bus0.sda = b;
        cycles(lo - 1);
        if (m) bus1.scl = 1'b1; else bus0.scl = 1'b0;
        cycles(hi);
        if (m) bus1.scl = 1'b0; else bus0.scl = 1'b1;
    endtask

    // Top n bits of w, MSB first.
    task automatic send_bits(input bit m, input logic [W-1:0] w, input int n, input int half);
        logic [W-1:0] v;
        v = w;
        @(negedge cin);
        for (int i = W - 1; i >= W - n; i--) send_bit(m, v[i], half);
    endtask

    task automatic send_word(input bit m, input logic [W-1:0] w, input int half);
        send_bits(m, w, W, half);
    endtask

    int e0, o0, n;
    logic [W-1:0] w;

    initial begin
        reset_n  = 1'b0;
        bus1.scl = 1'b0; bus1.sda = 1'b0;
        bus0.scl = 1'b1; bus0.sda = 1'b1;
        cycles(3);
        reset_n = 1'b1;

        // Idle line after reset.
        cycles(200);
        chk("idle_ordy1", bus1.ordy, 0);
        chk("idle_busy1", bus1.busy, 0);
        chk("idle_data1", bus1.data, 0);
        chk("idle_err1",  err1, 0);
        chk("idle_ordy0", bus0.ordy, 0);
        chk("idle_err0",  err0, 0);

        // Single word, exact completion latency, then acknowledge.
        send_word(1, 8'hA5, 8);
        @(posedge cin); #1 chk("lat_e1", bus1.ordy, 0);
        @(posedge cin); #1 chk("lat_e2", bus1.ordy, 0);
        @(posedge cin); #1 chk("lat_e3", bus1.ordy, 1);
        chk("single_data", bus1.data, 8'hA5);
        chk("single_busy", bus1.busy, 0);
        cycles(4);
        chk("hold_ordy", bus1.ordy, 1);
        auto1 = 1'b1;
        n = 0;
        while (bus1.ordy !== 1'b0 && n < 10) begin @(negedge cin); n++; end
        chk("ack_ordy", bus1.ordy, 0);
        chk("ack_word", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 8'hA5);
        rx1.delete();

        // Back-to-back words with acknowledge on the cycle ordy rises.
        o0 = ovr1;
        send_word(1, 8'h3C, 0);
        send_word(1, 8'hC3, 0);
        cycles(10);
        chk("b2b_cnt", rx1.size(), 2);
        if (rx1.size() == 2) begin
            chk("b2b_w0", rx1[0], 8'h3C);
            chk("b2b_w1", rx1[1], 8'hC3);
        end
        chk("b2b_ovr", ovr1 - o0, 0);
        rx1.delete();

        // Overrun: second word arrives while the first is still held.
        auto1 = 1'b0;
        cycles(2);
        o0 = ovr1;
        send_word(1, 8'h11, 0);
        cycles(6);
        chk("ovr_first_rdy", bus1.ordy, 1);
        chk("ovr_none_yet", ovr1 - o0, 0);
        send_word(1, 8'h22, 0);
        cycles(6);
        chk("ovr_data", bus1.data, 8'h11);
        chk("ovr_ordy", bus1.ordy, 1);
        chk("ovr_pulses", ovr1 - o0, 1);
        auto1 = 1'b1;
        cycles(4);
        chk("ovr_drain", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 8'h11);
        chk("ovr_clear", bus1.ordy, 0);
        rx1.delete();

        // Mid-word timeout, then a clean word.
        e0 = err1;
        send_bits(1, 8'($urandom), 3, 0);
        cycles(4);
        chk("to_busy", bus1.busy, 1);
        cycles(TO - 20);
        chk("to_early_err", err1 - e0, 0);
        chk("to_early_busy", bus1.busy, 1);
        cycles(30);
        chk("to_err", err1 - e0, 1);
        chk("to_busy_clr", bus1.busy, 0);
        chk("to_ordy", bus1.ordy, 0);
        send_word(1, 8'h5A, 0);
        cycles(8);
        chk("to_next", (rx1.size() == 1) ? rx1[0] : 32'hDEAD, 8'h5A);
        rx1.delete();

        // Random word stream with random gaps; must arrive in order, intact.
        sent.delete();
        o0 = ovr1; e0 = err1;
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            sent.push_back(w);
            send_word(1, w, 0);
            cycles($urandom_range(0, 20));
        end
        cycles(10);
        chk("rnd_cnt", rx1.size(), sent.size());
        for (int k = 0; k < sent.size() && k < rx1.size(); k++)
            chk($sformatf("rnd_w%0d", k), rx1[k], sent[k]);
        chk("rnd_ovr", ovr1 - o0, 0);
        chk("rnd_err", err1 - e0, 0);
        auto1 = 1'b0;
        rx1.delete();

        // Inverted scl polarity, then asynchronous reset in the middle of a word.
        e0 = err0;
        send_word(0, 8'h96, 0);
        cycles(6);
        chk("m0_ordy", bus0.ordy, 1);
        chk("m0_data", bus0.data, 8'h96);
        send_bits(0, 8'($urandom), 4, 0);
        cycles(3);
        chk("m0_busy", bus0.busy, 1);
        @(posedge cin);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ordy", bus0.ordy, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_data", bus0.data, 0);
        cycles(2);
        reset_n = 1'b1;
        send_word(0, 8'hF0, 0);
        cycles(6);
        chk("post_rst_data", bus0.data, 8'hF0);
        chk("post_rst_ordy", bus0.ordy, 1);
        chk("post_rst_err", err0 - e0, 0);
        auto0 = 1'b1;
        cycles(4);
        chk("post_rst_ack", bus0.ordy, 0);
        chk("post_rst_rx", (rx0.size() == 1) ? rx0[0] : 32'hDEAD, 8'hF0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Backstop so the run always ends even if a wait loop misbehaves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
